// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the eight-way round-robin one-hot arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_onehot_arbiter_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Rotation step applied to the pointer after a completed grant; the
    // IDXW-bit sum wraps naturally, so index 7 rotates back to 0.
    localparam logic [IDXW-1:0] ROT_STEP = IDXW'(1);

    function automatic logic [IDXW-1:0] onehot_idx(input logic [N-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Round-robin winner search: first set request at or after ptr, modulo N.
// Latency: combinational.
// Backpressure: none; output follows req/ptr directly.
module rr_pick
    import rr_onehot_arbiter_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    winner,
    output logic            any
);

    logic [IDXW-1:0] idx;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + IDXW'(i);
            if (req[idx]) winner = N'(1) << idx;
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant and hold timeout.
// Latency: 1 cycle from request to grant; back-to-back regrant on release.
// Backpressure: grant held until ack, withdrawal, or HOLD_MAX cycles elapse.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNTW     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         timeout
);

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MAX - 1);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] g;
    logic [CNTW-1:0] hold_cnt;
    logic [IDXW-1:0] search_ptr;
    logic [N-1:0]    winner;
    logic            any;
    logic            release_now;

    // While granting, search as if the pointer had already moved past g so the
    // current holder sits at lowest priority for a back-to-back regrant.
    assign search_ptr  = (state == GRANT) ? g + ROT_STEP : ptr;
    assign release_now = ack || (req[g] && hold_cnt == HOLD_LAST);
    assign busy        = |grant;

    rr_pick u_pick (
        .req    (req),
        .ptr    (search_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            timeout  <= 1'b0;
            ptr      <= '0;
            g        <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant    <= winner;
                        g        <= onehot_idx(winner);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr     <= search_ptr;
                        timeout <= !ack;
                        if (any) begin
                            grant    <= winner;
                            g        <= onehot_idx(winner);
                            hold_cnt <= '0;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end else if (!req[g]) begin
                        grant <= '0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNTW'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
